// File: rtl/axi4_slave_write_responder.sv
// AXI4 write-only slave front end: accepts one burst at a time, generates
// per-beat memory write strobes/addresses and a single B response.
module axi4_slave_write_responder #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = '0,
   parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS = 32'h0000_2FFF
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [15:0]                awid,
   input  logic [ADDRESS_WIDTH-1:0]   awaddr,
   input  logic [7:0]                 awlen,
   input  logic [2:0]                 awsize,
   input  logic [1:0]                 awburst,
   input  logic                       awlock,
   input  logic                       awvalid,
   output logic                       awready,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic [DATA_WIDTH/8-1:0]    wstrb,
   input  logic                       wlast,
   input  logic                       wvalid,
   output logic                       wready,
   output logic [15:0]                bid,
   output logic [1:0]                 bresp,
   output logic                       bvalid,
   input  logic                       bready,
   output logic                       mem_we,
   output logic [ADDRESS_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   output logic [DATA_WIDTH/8-1:0]    mem_wstrb
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int EW = ADDRESS_WIDTH + 9;
   localparam int AW = ADDRESS_WIDTH;
   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_INCR  = 2'b01;
   localparam logic [1:0] B_WRAP  = 2'b10;
   localparam logic [1:0] B_RSVD  = 2'b11;
   localparam logic [1:0] R_OKAY   = 2'b00;
   localparam logic [1:0] R_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t         state_q, state_d;
   logic           live_q;
   logic [15:0]    id_q, id_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [7:0]     len_q, len_d;
   logic [2:0]     size_q, size_d;
   logic [1:0]     burst_q, burst_d;
   logic           err_q, err_d;
   logic           bad_q, bad_d;
   logic [8:0]     beat_q, beat_d;

   // exclusive access is not supported, so awlock has no effect
   logic unused_lock;
   assign unused_lock = awlock;

   // AW legality check on a widened footprint so it cannot overflow
   logic [EW-1:0] aw_bytes, aw_cont, aw_first, aw_span, aw_last;
   logic [AW:0]   lo_diff;
   logic          aw_err;

   always_comb begin
      aw_bytes = EW'(1) << awsize;
      aw_cont  = EW'({1'b0, awlen} + 9'd1) << awsize;
      case (awburst)
         B_INCR: begin
            aw_first = {9'd0, awaddr} & ~(aw_bytes - EW'(1));
            aw_span  = aw_cont;
         end
         B_WRAP: begin
            aw_first = {9'd0, awaddr} & ~(aw_cont - EW'(1));
            aw_span  = aw_cont;
         end
         default: begin
            aw_first = {9'd0, awaddr} & ~(aw_bytes - EW'(1));
            aw_span  = aw_bytes;
         end
      endcase
      aw_last = aw_first + aw_span - EW'(1);
      lo_diff = {1'b0, awaddr} - {1'b0, MIN_ADDRESS};
      aw_err  = (awburst == B_RSVD)
             || (aw_bytes > EW'(NB))
             || ((awburst == B_WRAP) && !(awlen == 8'd1 || awlen == 8'd3
                  || awlen == 8'd7 || awlen == 8'd15))
             || lo_diff[AW]
             || (aw_last > {9'd0, MAX_ADDRESS});
   end

   logic [AW-1:0] bytes_a, cont_a, inc_a, lower_a, next_a;

   always_comb begin
      bytes_a = AW'(1) << size_q;
      cont_a  = AW'({1'b0, len_q} + 9'd1) << size_q;
      inc_a   = (addr_q & ~(bytes_a - AW'(1))) + bytes_a;
      lower_a = addr_q & ~(cont_a - AW'(1));
      case (burst_q)
         B_FIXED: next_a = addr_q;
         B_WRAP:  next_a = (inc_a == lower_a + cont_a) ? lower_a : inc_a;
         default: next_a = inc_a;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         live_q  <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         err_q   <= 1'b0;
         bad_q   <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         err_q   <= err_d;
         bad_q   <= bad_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (awvalid && live_q) state_d = DATA;
         DATA:    if (wvalid && wlast) state_d = RESP;
         RESP:    if (bready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      err_d   = err_q;
      bad_d   = bad_q;
      beat_d  = beat_q;
      if (state_q == IDLE && awvalid && live_q) begin
         id_d    = awid;
         addr_d  = awaddr;
         len_d   = awlen;
         size_d  = awsize;
         burst_d = awburst;
         err_d   = aw_err;
         bad_d   = 1'b0;
         beat_d  = '0;
      end else if (state_q == DATA && wvalid) begin
         // saturate so a runaway burst can never re-enable writes
         beat_d = (beat_q == 9'h1FF) ? beat_q : beat_q + 9'd1;
         addr_d = next_a;
         if (beat_q > {1'b0, len_q}) bad_d = 1'b1;
         if (wlast && beat_q < {1'b0, len_q}) bad_d = 1'b1;
      end
   end

   always_comb begin
      awready   = (state_q == IDLE) && live_q;
      wready    = (state_q == DATA);
      bvalid    = (state_q == RESP);
      bid       = id_q;
      bresp     = (err_q || bad_q) ? R_SLVERR : R_OKAY;
      mem_we    = (state_q == DATA) && wvalid && !err_q
               && (beat_q <= {1'b0, len_q});
      mem_addr  = addr_q;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
   end

endmodule

// File: doc/axi4_slave_write_responder.md
AXI4_SLAVE_WRITE_RESPONDER -- requirements
Module: axi4_slave_write_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ADDRESS_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width; multiple of 8.
- MIN_ADDRESS, 0, lowest legal byte address.
- MAX_ADDRESS, 32'h0000_2FFF, highest legal byte address.

REQ-002 SHALL have the following ports (name, direction, width, meaning); clock and reset are listed first:
- aclk, in, 1, sole clock.
- aresetn, in, 1, asynchronous active-low reset.
- awid/awaddr/awlen/awsize/awburst/awlock, in, 16/ADDRESS_WIDTH/8/3/2/1, write address channel.
- awvalid, in, 1, write address valid.
- awready, out, 1, write address ready.
- wdata/wstrb/wlast/wvalid, in, DATA_WIDTH/DATA_WIDTH/8/1/1, write data channel.
- wready, out, 1, write data ready.
- bid/bresp/bvalid, out, 16/2/1, write response channel.
- bready, in, 1, write response ready.
- mem_we, out, 1, memory byte-write enable.
- mem_addr, out, ADDRESS_WIDTH, beat byte address.
- mem_wdata, out, DATA_WIDTH, beat data.
- mem_wstrb, out, DATA_WIDTH/8, beat byte strobes.

REQ-003 SHALL encode bresp as OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11, and awburst as FIXED=00, INCR=01, WRAP=10, RESERVED=11.

Function
REQ-004 SHALL implement a three-state FSM: IDLE, DATA, RESP. Only one transaction is outstanding at a time.
REQ-005 In IDLE: awready=1, wready=0, bvalid=0. An AW handshake (awvalid&&awready) latches awid, awaddr, awlen, awsize, awburst and the error flag, clears the beat counter, and moves to DATA on the next cycle.
REQ-006 In DATA: awready=0, wready=1. Each W handshake increments the 9-bit beat counter. A handshake with wlast=1 moves to RESP on the next cycle.
REQ-007 In RESP: bvalid=1, bid=latched awid, bresp held stable until bready. The B handshake returns the FSM to IDLE on the next cycle.
- Resulting latency: first wready 1 cycle after the AW handshake; bvalid 1 cycle after the wlast handshake; awready 1 cycle after the B handshake.
REQ-008 The error flag SHALL be set at AW acceptance if any of the following holds:
- awburst=RESERVED;
- 2**awsize > DATA_WIDTH/8;
- awburst=WRAP and awlen not in {1,3,7,15};
- awaddr < MIN_ADDRESS;
- the last byte of the burst footprint > MAX_ADDRESS. The footprint is computed with ADDRESS_WIDTH+9 bits so it cannot overflow.
REQ-009 bresp SHALL be:
- SLVERR if the error flag is set, wlast arrives before beat awlen, or any beat arrives after beat awlen;
- otherwise OKAY, including when awlock=1 (exclusive access is not supported; EXOKAY is never issued).
REQ-010 mem_we SHALL equal wvalid && wready && !error_flag && beat_count<=awlen. It is combinational within the handshake cycle, and mem_wdata/mem_wstrb pass wdata/wstrb through.
REQ-011 mem_addr for beat n SHALL be:
- FIXED: awaddr for every beat.
- INCR: beat 0 = awaddr; beat n>0 = (awaddr aligned down to 2**awsize) + n*2**awsize.
- WRAP: container size = (awlen+1)*2**awsize and lower bound = awaddr aligned down to that size. Each increment that reaches lower bound + container size wraps to lower bound.
REQ-012 Beats after an early wlast or an error SHALL still be handshaken (wready=1) but SHALL NOT assert mem_we. This is the no-deadlock rule.
REQ-013 awvalid asserted during DATA or RESP SHALL be ignored (awready=0). wvalid asserted in IDLE SHALL NOT be accepted.
REQ-014 When bready is already 1 as bvalid rises, the handshake completes in that first RESP cycle.

Reset
REQ-015 While aresetn=0, and asynchronously on its falling edge:
- FSM=IDLE; awready=0, wready=0, bvalid=0, bid=0, bresp=OKAY, mem_we=0;
- all latched fields and the beat counter cleared.
REQ-016 awready SHALL rise in the first cycle after aresetn deasserts, sampled at the aclk edge.
REQ-017 Reset mid-burst SHALL discard the transaction: no B response is issued and no further mem_we is asserted.

Verification
REQ-018 INCR, awaddr=0x100, awlen=3, awsize=2, 4 beats with wlast on the 4th -> mem_addr 0x100, 0x104, 0x108, 0x10C; bresp=OKAY; bid=awid.
REQ-019 WRAP, awaddr=0x108, awlen=3, awsize=2 -> mem_addr 0x108, 0x10C, 0x100, 0x104; bresp=OKAY.
REQ-020 INCR, awaddr=0x2FFC, awlen=1, awsize=2 (footprint ends at 0x3003) -> 2 beats accepted, mem_we never asserted, bresp=SLVERR.
REQ-021 awlen=3 with wlast on beat 1 -> beats 0-1 written, FSM goes to RESP, bresp=SLVERR. Also awburst=11 -> SLVERR with no writes.
REQ-022 bready held low for 5 cycles -> bvalid, bid and bresp held stable throughout; a new awvalid is not accepted until the cycle after the B handshake.
REQ-023 aresetn pulsed low after beat 1 of a 4-beat burst -> all outputs at reset values immediately, no B response, and a fresh transaction afterwards completes with OKAY.
